// File: rtl/lift_scheduler.sv
// SCAN lift motion/door controller: serves pending requests in the current direction
// and reverses only when nothing is pending ahead. Optional door hold via DOOR_HOLD_EN.
module lift_scheduler #(
   parameter int unsigned N_FLOORS      = 8,
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] i_up_req_queue,
   input  logic [N_FLOORS-1:0] i_dn_req_queue,
   input  logic [N_FLOORS-1:0] i_flr_req_queue,
   output logic [N_FLOORS-1:0] o_flr_pos,
   output logic                o_up_clr,
   output logic                o_dn_clr,
   output logic                o_flr_clr,
   output logic                o_dir_up,
   output logic                o_moving,
   output logic                o_door_open
`ifdef DOOR_HOLD_EN
   ,
   input  logic                i_door_hold
`endif
);

   localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {S_EVAL, S_MOVE, S_DOOR} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_FLOORS-1:0] flr_pos_q, flr_pos_d;
   logic                dir_up_q, dir_up_d;
   logic                up_clr_q, up_clr_d;
   logic                dn_clr_q, dn_clr_d;
   logic                flr_clr_q, flr_clr_d;
   logic                moving_q, moving_d;
   logic                door_open_q, door_open_d;

   logic                serve_up_c, serve_dn_c;
   logic                door_hold_c;
   logic [N_FLOORS-1:0] pend_c, above_mask_c, below_mask_c;
   logic                above_c, below_c, here_up_c, here_dn_c;

`ifdef DOOR_HOLD_EN
   assign door_hold_c = i_door_hold;
`else
   assign door_hold_c = 1'b0;
`endif

   // Request decode relative to the one-hot car position
   assign pend_c       = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
   assign above_mask_c = ~((flr_pos_q << 1) - N_FLOORS'(1));
   assign below_mask_c = flr_pos_q - N_FLOORS'(1);
   assign above_c      = |(pend_c & above_mask_c);
   assign below_c      = |(pend_c & below_mask_c);
   assign here_up_c    = |((i_flr_req_queue | i_up_req_queue) & flr_pos_q);
   assign here_dn_c    = |((i_flr_req_queue | i_dn_req_queue) & flr_pos_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_EVAL;
         cnt_q       <= '0;
         flr_pos_q   <= N_FLOORS'(1);
         dir_up_q    <= 1'b1;
         up_clr_q    <= 1'b0;
         dn_clr_q    <= 1'b0;
         flr_clr_q   <= 1'b0;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flr_pos_q   <= flr_pos_d;
         dir_up_q    <= dir_up_d;
         up_clr_q    <= up_clr_d;
         dn_clr_q    <= dn_clr_d;
         flr_clr_q   <= flr_clr_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flr_pos_d  = flr_pos_q;
      dir_up_d   = dir_up_q;
      serve_up_c = 1'b0;
      serve_dn_c = 1'b0;
      unique case (state_q)
         S_EVAL: begin
            if (dir_up_q) begin
               if (here_up_c) begin
                  state_d    = S_DOOR;
                  serve_up_c = 1'b1;
               end else if (above_c) begin
                  state_d = S_MOVE;
               end else if (here_dn_c) begin
                  dir_up_d   = 1'b0;
                  state_d    = S_DOOR;
                  serve_dn_c = 1'b1;
               end else if (below_c) begin
                  dir_up_d = 1'b0;
                  state_d  = S_MOVE;
               end
            end else begin
               if (here_dn_c) begin
                  state_d    = S_DOOR;
                  serve_dn_c = 1'b1;
               end else if (below_c) begin
                  state_d = S_MOVE;
               end else if (here_up_c) begin
                  dir_up_d   = 1'b1;
                  state_d    = S_DOOR;
                  serve_up_c = 1'b1;
               end else if (above_c) begin
                  dir_up_d = 1'b1;
                  state_d  = S_MOVE;
               end
            end
         end
         S_MOVE: begin
            if (cnt_q == CNT_W'(TRAVEL_CYCLES - 1)) begin
               cnt_d     = '0;
               state_d   = S_EVAL;
               flr_pos_d = dir_up_q ? (flr_pos_q << 1) : (flr_pos_q >> 1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DOOR: begin
            if (door_hold_c) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_EVAL;
            cnt_d   = '0;
         end
      endcase
   end

   // Status flags track the next state; clear strobes mark entry into DOOR
   always_comb begin
      up_clr_d    = serve_up_c;
      dn_clr_d    = serve_dn_c;
      flr_clr_d   = serve_up_c | serve_dn_c;
      moving_d    = (state_d == S_MOVE);
      door_open_d = (state_d == S_DOOR);
   end

   assign o_flr_pos   = flr_pos_q;
   assign o_dir_up    = dir_up_q;
   assign o_up_clr    = up_clr_q;
   assign o_dn_clr    = dn_clr_q;
   assign o_flr_clr   = flr_clr_q;
   assign o_moving    = moving_q;
   assign o_door_open = door_open_q;

endmodule
